intersection_ctrl: RTL

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl_pkg.sv | 42 ++++
 rtl/intersection_ctrl_phase_timer.sv | 28 ++
 rtl/intersection_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/intersection_ctrl_pkg.sv
// Shared types and constants for the intersection controller.
// The WALK state exists only when INTERSECTION_PED_EN is defined.
package intersection_ctrl_pkg;

  typedef logic [7:0] timer_t;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5
`ifdef INTERSECTION_PED_EN
    ,WALK = 3'd6
`endif
  } state_t;

  // Lamp encoding, bit 0 is the leftmost (red) lamp
  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  // North-south lamp for a state; anything not NS-driven shows red
  function automatic logic [0:2] ns_lamp(input state_t s);
    case (s)
      NS_G:    return GREEN;
      NS_Y:    return YELLOW;
      default: return RED;
    endcase
  endfunction

  // East-west lamp for a state; anything not EW-driven shows red
  function automatic logic [0:2] ew_lamp(input state_t s);
    case (s)
      EW_G:    return GREEN;
      EW_Y:    return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase dwell timer: 8-bit down-counter loaded with dwell-1 on phase entry,
// saturates at zero, done while the count is zero.
module phase_timer
  import intersection_ctrl_pkg::*;
#(
  parameter timer_t RST_VAL = '0
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   i_load,
  input  timer_t i_dwell,
  output timer_t o_cnt,
  output logic   o_done
);

  timer_t r_cnt;

  // Load on phase entry, otherwise count down and hold at zero
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)              r_cnt <= RST_VAL;
    else if (i_load)          r_cnt <= i_dwell;
    else if (r_cnt != '0)     r_cnt <= r_cnt - timer_t'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way traffic light controller with optional pedestrian walk phase.
// Define INTERSECTION_PED_EN to enable the ped_req / WALK behaviour; without
// it ped_req is ignored and ped_walk / ped_ack stay low.
module intersection_ctrl
  import intersection_ctrl_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int MIN_GREEN  = 4,
  parameter int WALK_CYC   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ped_req,
  output logic [0:2] ns_light,
  output logic [0:2] ew_light,
  output logic       ped_walk,
  output logic       ped_ack
);

  localparam timer_t GREEN_LD  = timer_t'(GREEN_CYC - 1);
  localparam timer_t YELLOW_LD = timer_t'(YELLOW_CYC - 1);
  localparam timer_t ALLRED_LD = timer_t'(ALLRED_CYC - 1);
  localparam timer_t WALK_LD   = timer_t'(WALK_CYC - 1);
  // Count value at which MIN_GREEN cycles of green have been shown
  localparam timer_t TRUNC_AT  = timer_t'(GREEN_CYC - MIN_GREEN);

  state_t r_state, w_nxt;
  logic   w_go, w_done, w_pend;
  timer_t w_cnt, w_dwell;

`ifdef INTERSECTION_PED_EN
  logic r_pend;
  logic r_walk_ew;  // WALK resumes into EW_G (entered from RED_A) or NS_G
  assign w_pend = r_pend;
`else
  logic w_unused_ped;
  assign w_pend       = 1'b0;
  assign w_unused_ped = ped_req;
`endif

  // Next phase: expiry of the dwell, or green truncated by a pending walk
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      NS_G:  if (w_done || (w_pend && w_cnt <= TRUNC_AT)) w_nxt = NS_Y;
      NS_Y:  if (w_done) w_nxt = RED_A;
`ifdef INTERSECTION_PED_EN
      RED_A: if (w_done) w_nxt = r_pend ? WALK : EW_G;
`else
      RED_A: if (w_done) w_nxt = EW_G;
`endif
      EW_G:  if (w_done || (w_pend && w_cnt <= TRUNC_AT)) w_nxt = EW_Y;
      EW_Y:  if (w_done) w_nxt = RED_B;
`ifdef INTERSECTION_PED_EN
      RED_B: if (w_done) w_nxt = r_pend ? WALK : NS_G;
      WALK:  if (w_done) w_nxt = r_walk_ew ? EW_G : NS_G;
`else
      RED_B: if (w_done) w_nxt = NS_G;
`endif
      default: w_nxt = RED_B;  // illegal encoding recovers through all-red
    endcase
    w_go = (w_nxt != r_state);
  end

  // Dwell reload value for the phase being entered
  always_comb begin
    case (w_nxt)
      NS_G, EW_G:   w_dwell = GREEN_LD;
      NS_Y, EW_Y:   w_dwell = YELLOW_LD;
      RED_A, RED_B: w_dwell = ALLRED_LD;
      default:      w_dwell = WALK_LD;
    endcase
  end

  phase_timer #(.RST_VAL(ALLRED_LD)) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_go),
    .i_dwell (w_dwell),
    .o_cnt   (w_cnt),
    .o_done  (w_done)
  );

  // State, lamps and pedestrian outputs all registered off the next phase
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= RED_B;
      ns_light  <= RED;
      ew_light  <= RED;
      ped_walk  <= 1'b0;
      ped_ack   <= 1'b0;
`ifdef INTERSECTION_PED_EN
      r_pend    <= 1'b0;
      r_walk_ew <= 1'b0;
`endif
    end else begin
      r_state  <= w_nxt;
      ns_light <= ns_lamp(w_nxt);
      ew_light <= ew_lamp(w_nxt);
`ifdef INTERSECTION_PED_EN
      ped_walk <= (w_nxt == WALK);
      ped_ack  <= (w_nxt == WALK) && (r_state != WALK);
      if (w_nxt == WALK && r_state != WALK) begin
        r_pend    <= 1'b0;
        r_walk_ew <= (r_state == RED_A);
      end else if (ped_req && r_state != WALK) begin
        r_pend <= 1'b1;
      end
`else
      ped_walk <= 1'b0;
      ped_ack  <= 1'b0;
`endif
    end
  end

endmodule
